// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with runtime reload, overlap control and saturating match counter
module seq_detector_param #(
    parameter int LEN = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0110,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic [LEN-1:0]   pat,
    input  logic             pat_load,
    input  logic             clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int FW = $clog2(LEN);

    logic [LEN-1:0]   pat_q, pat_d, cand;
    logic [LEN-2:0]   hist, hist_d;
    logic [FW-1:0]    fill, fill_d;
    logic [CNT_W-1:0] cnt_d;
    logic             acc, full, match;

    assign cnt_sat = &match_cnt;

    always_comb begin
        acc    = en & ~pat_load;
        cand   = {hist, x};
        full   = fill == FW'(LEN - 1);
        match  = acc & full & (cand == pat_q);
        pat_d  = pat_load ? pat : pat_q;
        hist_d = acc ? cand[LEN-2:0] : hist;
        // a non-overlapping match forces a full refill of LEN fresh bits
        fill_d = (pat_load || (match && !overlap)) ? '0 : (acc && !full) ? fill + 1'b1 : fill;
        cnt_d  = clr ? '0 : (match && !cnt_sat) ? match_cnt + 1'b1 : match_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q     <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            hist      <= hist_d;
            fill      <= fill_d;
            match_cnt <= cnt_d;
            z         <= match;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: random and directed checks of seq_detector_param against a queue-based reference model
module tb_seq_detector_param;
    logic       clk = 0, rst = 0, en = 0, x = 0, overlap = 0, pat_load = 0, clr = 0;
    logic [3:0] pat = 0;
    logic       z, z2, sat, sat2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int         n_cmp = 0, n_bad = 0;

    bit         q[$];
    logic [3:0] pat_m;
    int         cnt8_m, cnt2_m;
    logic       z_m;

    always #5 clk = ~clk;

    seq_detector_param u_dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat(pat),
        .pat_load(pat_load), .clr(clr), .z(z), .match_cnt(cnt), .cnt_sat(sat)
    );

    seq_detector_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat(pat),
        .pat_load(pat_load), .clr(clr), .z(z2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pat_m  = 4'b0110;
        cnt8_m = 0;
        cnt2_m = 0;
        z_m    = 0;
    endtask

    // reference: window of accepted bits since the last restart, oldest first
    task automatic model_step();
        bit hit;
        z_m = 0;
        if (pat_load) begin
            pat_m = pat;
            q.delete();
        end else if (en) begin
            q.push_back(x);
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) begin
                hit = 1;
                for (int i = 0; i < 4; i++) if (q[i] != pat_m[3-i]) hit = 0;
                if (hit) begin
                    z_m = 1;
                    if (cnt8_m < 255) cnt8_m++;
                    if (cnt2_m < 3) cnt2_m++;
                    if (!overlap) q.delete();
                end
            end
        end
        if (clr) begin
            cnt8_m = 0;
            cnt2_m = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".z"}, int'(z), int'(z_m));
        chk({tag, ".cnt"}, int'(cnt), cnt8_m);
        chk({tag, ".sat"}, int'(sat), int'(cnt8_m == 255));
        chk({tag, ".z2"}, int'(z2), int'(z_m));
        chk({tag, ".cnt2"}, int'(cnt2), cnt2_m);
        chk({tag, ".sat2"}, int'(sat2), int'(cnt2_m == 3));
    endtask

    task automatic cyc(input string tag, input logic e, input logic xi, input logic ov,
                       input logic pl, input logic [3:0] p, input logic c);
        en = e; x = xi; overlap = ov; pat_load = pl; pat = p; clr = c;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic ov, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(tag, 1, bits[i], ov, 0, 4'h0, 0);
    endtask

    // async assert mid-cycle, a few clocks with random inputs, release at negedge
    task automatic do_reset(input int n);
        #2 rst = 0;
        model_reset();
        #1 check_all("rst_async");
        for (int i = 0; i < n; i++) begin
            {en, x, overlap, pat_load, clr} = 5'($urandom);
            pat = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_all("rst_hold");
        end
        rst = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(4);

        send("rst_rel", 0, 16'b0110, 4);

        do_reset(1);
        send("ovl", 1, 16'b0110110, 7);
        chk("ovl_total", int'(cnt), 2);

        do_reset(1);
        send("novl", 0, 16'b0110110, 7);
        chk("novl_total", int'(cnt), 1);

        do_reset(1);
        send("gap", 0, 16'b01, 2);
        for (int i = 0; i < 3; i++) cyc("gap_idle", 0, 1, 0, 0, 4'h0, 0);
        send("gap", 0, 16'b10, 2);
        chk("gap_total", int'(cnt), 1);

        do_reset(1);
        send("reload", 0, 16'b011, 3);
        cyc("reload_ld", 1, 0, 0, 1, 4'b1001, 0);
        send("reload", 0, 16'b1001, 4);
        chk("reload_total", int'(cnt), 1);

        do_reset(1);
        send("midrst", 0, 16'b01, 2);
        do_reset(0);
        send("midrst", 0, 16'b10, 2);
        chk("midrst_total", int'(cnt), 0);

        do_reset(1);
        send("satc", 1, 16'b0110, 4);
        for (int i = 0; i < 4; i++) send("satc", 1, 16'b110, 3);
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_flag2", int'(sat2), 1);
        send("satc", 1, 16'b11, 2);
        cyc("sat_clr", 1, 0, 1, 0, 4'h0, 1);
        chk("clr_z2", int'(z2), 1);
        chk("clr_cnt2", int'(cnt2), 0);

        do_reset(1);
        cyc("sat8_ld", 1, 0, 1, 1, 4'b0000, 0);
        for (int i = 0; i < 270; i++) cyc("sat8", 1, 0, 1, 0, 4'h0, 0);
        chk("sat8_flag", int'(sat), 1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 2));
            cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter LEN, default 4, giving the pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b0110 (width LEN), giving the pattern loaded at reset.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match counter width (legal 1..32).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (asserted at 0).
REQ-006 The block SHALL have port en, input, 1 bit: when 1, x is sampled this cycle.
REQ-007 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 The block SHALL have port pat, input, LEN bits: new pattern value.
REQ-010 The block SHALL have port pat_load, input, 1 bit: synchronous strobe that loads pat.
REQ-011 The block SHALL have port clr, input, 1 bit: synchronous clear of the match counter.
REQ-012 The block SHALL have port z, output, 1 bit: registered one-cycle match pulse.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-014 The block SHALL have port cnt_sat, output, 1 bit: 1 when match_cnt equals 2^CNT_W-1.

Function
REQ-015 The block SHALL hold an active pattern register pat_q, a history shift register hist (LEN-1 bits) and a fill counter fill (0..LEN-1, saturating).
REQ-016 Bit order SHALL be: the oldest received bit compares against pat_q[LEN-1] and the newest against pat_q[0].
REQ-017 An accepted bit SHALL be a cycle with en=1 and pat_load=0.
REQ-018 On an accepted bit, candidate = {hist, x}; match SHALL be 1 iff fill == LEN-1 and candidate == pat_q.
REQ-019 On an accepted bit, hist SHALL shift left taking x in at bit 0.
REQ-020 On an accepted bit, fill SHALL increment, saturating at LEN-1, except as stated in REQ-021.
REQ-021 On match with overlap=0, fill SHALL be set to 0 so that the next match needs LEN fresh bits; with overlap=1, fill SHALL remain LEN-1.
REQ-022 z SHALL be registered: z=1 in the cycle after the accepted bit that completes a match, otherwise 0 (latency 1, width 1 cycle).
REQ-023 When en=0 and pat_load=0, hist, fill, pat_q and match_cnt SHALL hold and z SHALL be 0 next cycle.
REQ-024 pat_load=1 SHALL set pat_q<=pat and fill<=0; the same-cycle x SHALL be discarded (even if en=1) and z SHALL be 0 next cycle.
REQ-025 On match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-026 clr=1 SHALL set match_cnt<=0; on a simultaneous match, clr SHALL win (count 0) while z still pulses.
REQ-027 cnt_sat SHALL be combinational from match_cnt.
REQ-028 overlap SHALL be sampled every cycle; a change takes effect on the next match decision.

Reset
REQ-029 While rst=0, asynchronously: z=0, match_cnt=0, cnt_sat=0, fill=0, hist=0, pat_q=PATTERN.
REQ-030 Reset asserted mid-pattern SHALL discard partial history; after release, detection restarts needing LEN accepted bits.
REQ-031 The first rising edge after rst returns to 1 SHALL operate normally.

Verification (LEN=4, PATTERN=0110, CNT_W=8 unless stated)
REQ-032 Reset: rst=0 with random inputs -> z=0, match_cnt=0, cnt_sat=0; after release, stream 0110 -> z pulse after the 4th bit.
REQ-033 Overlap: overlap=1, en=1, stream 0,1,1,0,1,1,0 -> z=1 in the cycles after bits 4 and 7; match_cnt=2.
REQ-034 Non-overlap: overlap=0, same stream -> z=1 only after bit 4; match_cnt=1.
REQ-035 Gaps: stream 0,1 then en=0 for 3 cycles then 1,0 -> single z pulse in the cycle after the final accepted bit; no pulse during the gap.
REQ-036 Reload: after bits 0,1,1, pat_load=1 with pat=1001 and en=1, x=0, then stream 1,0,0,1 -> no z until the cycle after the 4th new bit; then z=1 and match_cnt=1.
REQ-037 Saturation/clear: CNT_W=2, 5 matches -> match_cnt=3 and cnt_sat=1; clr asserted together with a 6th match -> z=1 and match_cnt=0.
